qft_phase_gen: RTL and testbench
================================

QFT_PHASE_GEN -- requirements
Module: qft_phase_gen

Interface
REQ-001: Parameter N_MAX_QUBITS, default 3, gives the maximum supported qubit count; the transform size is N = 2^n_qubits, at most 8.
REQ-002: clk  input  1  single clock; all logic is rising-edge.
REQ-003: rst  input  1  reset, synchronous and active-high.
REQ-004: start  input  1  single-cycle request to begin a phase sweep.
REQ-005: n_qubits  input  2  qubit count 1..3, sampled when start is accepted.
REQ-006: busy  output  1  high from start acceptance until the cycle done is asserted.
REQ-007: out_valid  output  1  out_angle, out_row, out_col and out_last are valid.
REQ-008: out_ready  input  1  downstream cosine stage accepts the current output.
REQ-009: out_angle  output  8  signed S3.4 angle in [-pi, pi), feeding the cosine stage.
REQ-010: out_row  output  3  row index j of the current element.
REQ-011: out_col  output  3  column index k of the current element.
REQ-012: out_last  output  1  high on the final element, j = k = N-1.
REQ-013: done  output  1  one-cycle pulse after the last element is accepted.
REQ-014: err  output  1  one-cycle pulse when start is seen with n_qubits = 0 while idle.

Function
REQ-015: The FSM has four states: IDLE, RUN, FLUSH and DONE.
REQ-016: In IDLE, start with n_qubits in 1..3 latches n_qubits, clears j and k to 0, and moves to RUN.
REQ-017: In IDLE, start with n_qubits = 0 pulses err the next cycle and stays in IDLE.
REQ-018: start while not in IDLE is ignored, with no err.
REQ-019: In RUN, one (j,k) pair enters the pipeline per non-stalled cycle, in row-major order with k fastest.
REQ-020: After issuing (N-1,N-1), the FSM moves to FLUSH.
REQ-021: FLUSH moves to DONE when out_valid && out_ready && out_last.
REQ-022: DONE asserts done for one cycle, deasserts busy, and returns to IDLE.
REQ-023: Stage 1 computes p = (j*k) mod N, as the low n_qubits bits of a 6-bit product.
REQ-024: Stage 1 then computes p8 = p << (3 - n_qubits), a 3-bit value in eighths of a turn.
REQ-025: Stage 2 wraps p8: values 0..3 map to m = p8; values 4..7 map to m = p8 - 8, so m is in -4..3.
REQ-026: Stage 2 performs a LUT lookup giving out_angle = round(m*pi/4*16).
REQ-027: The LUT values for m = -4..3 are -50, -38, -25, -13, 0, 13, 25, 38.
REQ-028: Latency: start accepted at edge T gives the first out_valid after edge T+2.
REQ-029: With out_ready held high, throughput is one element per cycle, N*N elements per sweep.
REQ-030: Stall is defined as out_valid && !out_ready.
REQ-031: During stall, all pipeline registers, outputs and indices hold, and no element is lost or duplicated.
REQ-032: out_valid may not drop without acceptance; outputs stay stable while out_valid && !out_ready.
REQ-033: out_row, out_col and out_last travel with their angle through both stages.
REQ-034: Multiplication is unsigned 3x3 to 6 bits; no other arithmetic overflow is possible.

Reset
REQ-035: rst sampled high forces IDLE on the same edge and clears all pipeline valid bits.
REQ-036: On reset, busy, out_valid, done, err and out_last go to 0, and out_angle, out_row and out_col go to 0.
REQ-037: Reset mid-sweep discards in-flight elements, with no done pulse.
REQ-038: start asserted in the same cycle as rst is ignored.

Structure
REQ-039: The shared header holds: TOTAL_WIDTH = 8 (S3.4), the QFT_MAX_QUBITS constant, the FSM state encodings, and the eight S3.4 multiples of pi/4.
REQ-040: The angle table is one sub-module, qft_angle_lut: 3-bit signed m in, 8-bit S3.4 angle out, purely combinational.
REQ-041: Everything else (FSM, counters, two-stage pipeline) is in qft_phase_gen.

Verification
REQ-042: n_qubits=3, out_ready=1 -> 64 outputs on consecutive cycles; (j=3,k=5) gives 0xF3 (-13); (j=2,k=2) gives 0xCE (-50); out_last only on (7,7); done one cycle after it.
REQ-043: n_qubits=1 -> 4 outputs with angles 0, 0, 0, -50; n_qubits=2, (j=3,k=3) -> 25.
REQ-044: n_qubits=3, out_ready toggled randomly at 50% -> 64 unique (j,k) accepted in order; angles match REQ-023 to REQ-027; outputs stable during every stall.
REQ-045: rst pulsed while element 20 is stalled -> next cycle out_valid=0 and busy=0, no done; a new start gives a full clean sweep.
REQ-046: start with n_qubits=0 in IDLE -> err pulse, busy stays 0; start during RUN -> ignored, and the sweep count stays 64.

Source files
------------

// File: rtl/qft_phase_gen_pkg.sv
// Shared constants for the QFT phase generator: angle format, qubit limit,
// FSM state encodings and the eight S3.4 multiples of pi/4.
// Ports: none (package only).
package qft_phase_gen_pkg;

  // Signed S3.4 angle: 1 sign, 3 integer, 4 fraction bits.
  localparam int TOTAL_WIDTH    = 8;
  localparam int QFT_MAX_QUBITS = 3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // round(m * pi/4 * 16) for m = -4..3
  localparam logic signed [TOTAL_WIDTH-1:0] ANG_M4 = -8'sd50;
  localparam logic signed [TOTAL_WIDTH-1:0] ANG_M3 = -8'sd38;
  localparam logic signed [TOTAL_WIDTH-1:0] ANG_M2 = -8'sd25;
  localparam logic signed [TOTAL_WIDTH-1:0] ANG_M1 = -8'sd13;
  localparam logic signed [TOTAL_WIDTH-1:0] ANG_P0 =  8'sd0;
  localparam logic signed [TOTAL_WIDTH-1:0] ANG_P1 =  8'sd13;
  localparam logic signed [TOTAL_WIDTH-1:0] ANG_P2 =  8'sd25;
  localparam logic signed [TOTAL_WIDTH-1:0] ANG_P3 =  8'sd38;

endpackage

// File: rtl/qft_angle_lut.sv
// Maps a wrapped phase m (eighths of a turn, -4..3) to an S3.4 angle in radians.
// Purely combinational, zero latency.
// Ports: m (3-bit signed phase), angle (8-bit signed S3.4 result).
module qft_angle_lut
  import qft_phase_gen_pkg::*;
(
  input  logic signed [2:0]             m,
  output logic signed [TOTAL_WIDTH-1:0] angle
);

  always_comb begin
    angle = ANG_P0;
    unique case (m)
      3'sb100: angle = ANG_M4;
      3'sb101: angle = ANG_M3;
      3'sb110: angle = ANG_M2;
      3'sb111: angle = ANG_M1;
      3'sb000: angle = ANG_P0;
      3'sb001: angle = ANG_P1;
      3'sb010: angle = ANG_P2;
      3'sb011: angle = ANG_P3;
    endcase
  end

endmodule

// File: rtl/qft_phase_gen.sv
// Sweeps every (j,k) of an N x N QFT matrix and emits the phase angle 2*pi*j*k/N.
// Latency: start accepted at edge T gives first out_valid after edge T+2; 1 elem/cycle.
// Backpressure: out_valid && !out_ready freezes indices, both stages and outputs.
// Ports: clk/rst (sync, active-high); start/n_qubits request a sweep; busy/done/err
// report status; out_valid/out_ready handshake carries out_angle, out_row, out_col, out_last.
module qft_phase_gen
  import qft_phase_gen_pkg::*;
#(
  parameter int N_MAX_QUBITS = QFT_MAX_QUBITS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [1:0]             n_qubits,
  output logic                   busy,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [TOTAL_WIDTH-1:0] out_angle,
  output logic [2:0]             out_row,
  output logic [2:0]             out_col,
  output logic                   out_last,
  output logic                   done,
  output logic                   err
);

  logic [1:0] state;
  logic [1:0] n_q;
  logic [2:0] j_idx;
  logic [2:0] k_idx;

  logic       stall;
  logic       adv;
  logic       issue;
  logic       issue_last;
  logic       n_ok;
  logic [2:0] idx_max;
  logic [2:0] p;
  logic [2:0] p8;

  // stage 1 register
  logic       s1_vld;
  logic [2:0] s1_p8;
  logic [2:0] s1_row;
  logic [2:0] s1_col;
  logic       s1_last;

  logic signed [TOTAL_WIDTH-1:0] lut_angle;

  assign stall      = out_valid && !out_ready;
  assign adv        = !stall;
  assign idx_max    = 3'((4'd1 << n_q) - 4'd1);
  assign issue      = (state == ST_RUN) && adv;
  assign issue_last = (j_idx == idx_max) && (k_idx == idx_max);
  assign n_ok       = (n_qubits != 2'd0) && (int'({30'd0, n_qubits}) <= N_MAX_QUBITS);

  // Only the low n bits of the 6-bit product survive the mod N, so keep 3.
  assign p  = 3'({3'd0, j_idx} * {3'd0, k_idx}) & idx_max;
  // Rescale to eighths of a turn; p < 2^n so nothing is shifted out.
  assign p8 = p << (2'd3 - n_q);

  assign busy = (state == ST_RUN) || (state == ST_FLUSH);
  assign done = (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      n_q   <= 2'd0;
      j_idx <= 3'd0;
      k_idx <= 3'd0;
      err   <= 1'b0;
    end else begin
      err <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            if (n_ok) begin
              n_q   <= n_qubits;
              j_idx <= 3'd0;
              k_idx <= 3'd0;
              state <= ST_RUN;
            end else begin
              err <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (issue) begin
            if (issue_last) begin
              state <= ST_FLUSH;
            end else if (k_idx == idx_max) begin
              k_idx <= 3'd0;
              j_idx <= j_idx + 3'd1;
            end else begin
              k_idx <= k_idx + 3'd1;
            end
          end
        end
        ST_FLUSH: begin
          if (out_valid && out_ready && out_last) state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
      endcase
    end
  end

  qft_angle_lut u_lut (
    .m     (s1_p8),
    .angle (lut_angle)
  );

  // Both stages advance together; a stall freezes everything in place.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld    <= 1'b0;
      s1_p8     <= 3'd0;
      s1_row    <= 3'd0;
      s1_col    <= 3'd0;
      s1_last   <= 1'b0;
      out_valid <= 1'b0;
      out_angle <= '0;
      out_row   <= 3'd0;
      out_col   <= 3'd0;
      out_last  <= 1'b0;
    end else if (adv) begin
      s1_vld    <= issue;
      s1_p8     <= p8;
      s1_row    <= j_idx;
      s1_col    <= k_idx;
      s1_last   <= issue && issue_last;
      out_valid <= s1_vld;
      out_angle <= lut_angle;
      out_row   <= s1_row;
      out_col   <= s1_col;
      out_last  <= s1_vld && s1_last;
    end
  end

endmodule

// File: tb/tb_qft_phase_gen.sv
module tb_qft_phase_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] n_qubits;
  logic       busy;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_angle;
  logic [2:0] out_row;
  logic [2:0] out_col;
  logic       out_last;
  logic       done;
  logic       err;

  int checks = 0;
  int errors = 0;

  logic [7:0] grid [8][8];

  typedef struct {
    int         n;
    int         j;
    int         k;
    logic [7:0] exp_angle;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  qft_phase_gen dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .n_qubits  (n_qubits),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_angle (out_angle),
    .out_row   (out_row),
    .out_col   (out_col),
    .out_last  (out_last),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Independent reference: phase in eighths of a turn, wrapped, scaled by 4*pi.
  function automatic logic [7:0] model_angle(int n, int j, int k);
    int  nn;
    int  m;
    real a;
    int  r;
    nn = 1 << n;
    m  = ((j * k) % nn) * 8 / nn;
    if (m >= 4) m = m - 8;
    a = m * 3.141592653589793 * 4.0;
    r = (a >= 0.0) ? $rtoi(a + 0.5) : -$rtoi(-a + 0.5);
    return 8'(r);
  endfunction

  task automatic apply_table(input int n);
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].n == n)
        chk($sformatf("vec%0d_n%0d_j%0d_k%0d", i, vecs[i].n, vecs[i].j, vecs[i].k),
            int'(grid[vecs[i].j][vecs[i].k]), int'(vecs[i].exp_angle));
    end
  endtask

  task automatic run_sweep(input int n, input bit rnd, input bit poke, input string tag);
    int nn;
    int ej, ek, cyc, cnt;
    int first_cyc, last_cyc, done_cyc;
    int ord_err, ang_err, last_err, stab_err, err_seen, busy_err;
    bit held;
    logic [7:0] h_ang;
    logic [2:0] h_row, h_col;
    logic h_last;
    nn = 1 << n;
    ej = 0; ek = 0; cyc = 0; cnt = 0;
    first_cyc = -1; last_cyc = -1; done_cyc = -1;
    ord_err = 0; ang_err = 0; last_err = 0; stab_err = 0; err_seen = 0; busy_err = 0;
    held = 0; h_ang = '0; h_row = '0; h_col = '0; h_last = 0;
    for (int a = 0; a < 8; a++)
      for (int b = 0; b < 8; b++) grid[a][b] = 8'h5A;
    start = 1'b1; n_qubits = 2'(n); out_ready = 1'b1;
    step();
    start = 1'b0;
    while (done_cyc < 0 && cyc < 3000) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start     = poke && (cyc == 10 || cyc == 12);
      n_qubits  = (cyc == 12) ? 2'd0 : 2'd1;
      if (held) begin
        if (!out_valid || out_angle !== h_ang || out_row !== h_row ||
            out_col !== h_col || out_last !== h_last) stab_err++;
      end
      held = 0;
      if (err) err_seen++;
      if (done) begin
        done_cyc = cyc;
        if (busy) busy_err++;
      end else if (!busy) busy_err++;
      if (out_valid && out_ready) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (out_row !== 3'(ej) || out_col !== 3'(ek)) ord_err++;
        if (out_angle !== model_angle(n, int'(out_row), int'(out_col))) ang_err++;
        if (out_last !== (ej == nn - 1 && ek == nn - 1)) last_err++;
        grid[out_row][out_col] = out_angle;
        cnt++;
        if (out_last) last_cyc = cyc;
        if (ek == nn - 1) begin ek = 0; ej++; end else ek++;
      end else if (out_valid) begin
        held = 1; h_ang = out_angle; h_row = out_row; h_col = out_col; h_last = out_last;
      end
      step();
      cyc++;
    end
    start = 1'b0; out_ready = 1'b1;
    chk({tag, "_done_seen"}, int'(done_cyc >= 0), 1);
    chk({tag, "_count"}, cnt, nn * nn);
    chk({tag, "_order"}, ord_err, 0);
    chk({tag, "_angle"}, ang_err, 0);
    chk({tag, "_last_flag"}, last_err, 0);
    chk({tag, "_done_after_last"}, done_cyc, last_cyc + 1);
    chk({tag, "_busy"}, busy_err, 0);
    chk({tag, "_done_pulse_ends"}, int'(done), 0);
    if (rnd) chk({tag, "_stall_stable"}, stab_err, 0);
    else chk({tag, "_back_to_back"}, last_cyc - first_cyc, nn * nn - 1);
    if (poke) chk({tag, "_no_err_while_busy"}, err_seen, 0);
  endtask

  initial begin
    int cnt, cyc;

    vecs[0]  = '{1, 0, 0, 8'h00};
    vecs[1]  = '{1, 0, 1, 8'h00};
    vecs[2]  = '{1, 1, 0, 8'h00};
    vecs[3]  = '{1, 1, 1, 8'hCE};
    vecs[4]  = '{2, 3, 3, 8'h19};
    vecs[5]  = '{2, 1, 2, 8'hCE};
    vecs[6]  = '{2, 1, 1, 8'h19};
    vecs[7]  = '{2, 1, 3, 8'hE7};
    vecs[8]  = '{3, 3, 5, 8'hF3};
    vecs[9]  = '{3, 2, 2, 8'hCE};
    vecs[10] = '{3, 1, 1, 8'h0D};
    vecs[11] = '{3, 7, 7, 8'h0D};
    vecs[12] = '{3, 2, 3, 8'hE7};
    vecs[13] = '{3, 1, 3, 8'h26};
    vecs[14] = '{3, 4, 6, 8'h00};
    vecs[15] = '{3, 5, 5, 8'h0D};

    rst = 1'b1; start = 1'b0; n_qubits = 2'd0; out_ready = 1'b1;
    step(); step();
    rst = 1'b0;
    chk("rst_busy", int'(busy), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_out_last", int'(out_last), 0);
    chk("rst_out_angle", int'(out_angle), 0);
    chk("rst_out_row", int'(out_row), 0);
    chk("rst_out_col", int'(out_col), 0);

    // n_qubits = 0 in IDLE: err pulse, no sweep
    start = 1'b1; n_qubits = 2'd0;
    step();
    start = 1'b0;
    chk("err_pulse", int'(err), 1);
    chk("err_busy", int'(busy), 0);
    step();
    chk("err_pulse_ends", int'(err), 0);
    chk("err_still_idle", int'(busy), 0);

    // First-output latency, then reset mid-sweep
    start = 1'b1; n_qubits = 2'd3;
    step();
    start = 1'b0;
    chk("lat_busy_T", int'(busy), 1);
    chk("lat_valid_T", int'(out_valid), 0);
    step();
    chk("lat_valid_T1", int'(out_valid), 0);
    step();
    chk("lat_valid_T2", int'(out_valid), 1);
    chk("lat_first_row", int'(out_row), 0);
    chk("lat_first_col", int'(out_col), 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_valid", int'(out_valid), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);

    run_sweep(1, 1'b0, 1'b0, "n1");
    apply_table(1);
    run_sweep(2, 1'b0, 1'b0, "n2");
    apply_table(2);
    run_sweep(3, 1'b0, 1'b1, "n3");
    apply_table(3);
    run_sweep(3, 1'b1, 1'b0, "n3_rnd");
    apply_table(3);

    // Stall on element 20 (j=2,k=4), then reset with start in the same cycle
    start = 1'b1; n_qubits = 2'd3; out_ready = 1'b1;
    step();
    start = 1'b0;
    cnt = 0; cyc = 0;
    while (cnt < 20 && cyc < 200) begin
      if (out_valid && out_ready) cnt++;
      step();
      cyc++;
    end
    out_ready = 1'b0;
    chk("e20_reached", cnt, 20);
    step(); step();
    chk("e20_stall_valid", int'(out_valid), 1);
    chk("e20_stall_row", int'(out_row), 2);
    chk("e20_stall_col", int'(out_col), 4);
    chk("e20_stall_angle", int'(out_angle), 0);
    rst = 1'b1; start = 1'b1; n_qubits = 2'd3;
    step();
    rst = 1'b0; start = 1'b0; out_ready = 1'b1;
    chk("e20_rst_valid", int'(out_valid), 0);
    chk("e20_rst_busy", int'(busy), 0);
    chk("e20_rst_done", int'(done), 0);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (busy || done || out_valid) cnt++;
    end
    chk("e20_start_with_rst_ignored", cnt, 0);
    run_sweep(3, 1'b0, 1'b0, "after_rst");
    apply_table(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
